dp_issue_sched: RTL and testbench

Round-robin issue scheduler that shares one fixed-latency, non-stallable register datapath (single-bit `in` → `out`, LAT register stages, no enables) among NREQ requesters. Each cycle it grants at most one eligible requester, drives that requester's bit onto the datapath input, and tracks the issue through a tag shift register. When the result emerges LAT cycles later, it returns the result to the owning requester. It sits above the datapath instance and is the only driver of that datapath's input.

---
 rtl/dp_issue_sched.sv | 166 ++++++++++++++++
 tb/tb_dp_issue_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_issue_sched.sv
// dp_issue_sched
// Round-robin issue scheduler in front of a fixed-latency, non-stallable
// single-bit register datapath. Each cycle it grants at most one eligible
// requester and drives that requester's operand onto the datapath input. A
// tag shift register, LAT+1 stages deep, moves in lock-step with the
// datapath, so the owner of each result is known when the result emerges.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        level request per requester
//   req_data   operand bit per requester, sampled at that requester's grant edge
//   hold       blocks new grants; in-flight items still drain
//   grant      one-hot (or zero) grant pulse
//   dp_in      datapath input bit
//   dp_out     datapath output bit
//   rsp_valid  one-hot (or zero) completion pulse
//   rsp_data   result bit, qualified by rsp_valid
//   inflight   number of requesters with an outstanding item
//   drained    1 when inflight is zero
module dp_issue_sched #(
   parameter int NREQ = 3,
   parameter int LAT  = 4,
   localparam int TAGW = ($clog2(NREQ) < 1) ? 1 : $clog2(NREQ),
   localparam int CNTW = $clog2(NREQ + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] req_data,
   input  logic            hold,
   output logic [NREQ-1:0] grant,
   output logic            dp_in,
   input  logic            dp_out,
   output logic [NREQ-1:0] rsp_valid,
   output logic            rsp_data,
   output logic [CNTW-1:0] inflight,
   output logic            drained
);

   // Expand a requester index into a one-hot vector.
   function automatic logic [NREQ-1:0] onehot_f(input logic [TAGW-1:0] idx);
      logic [NREQ-1:0] v;
      v = {NREQ{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         if (idx == TAGW'(i)) begin
            v[i] = 1'b1;
         end
      end
      return v;
   endfunction

   // Count the set bits of a requester vector.
   function automatic logic [CNTW-1:0] popcount_f(input logic [NREQ-1:0] v);
      logic [CNTW-1:0] c;
      c = {CNTW{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         c = c + CNTW'(v[i]);
      end
      return c;
   endfunction

   logic [NREQ-1:0]           pend_r;
   logic [TAGW-1:0]           ptr_r;
   logic [LAT:0]              tag_vld_r;
   logic [LAT:0][TAGW-1:0]    tag_r;

   logic [NREQ-1:0]           elig_s;
   logic [TAGW:0]             idx_s;
   logic                      found_s;
   logic [TAGW-1:0]           win_s;
   logic [TAGW-1:0]           ptr_nx_s;
   logic                      cmp_vld_s;
   logic [TAGW-1:0]           cmp_tag_s;
   logic [NREQ-1:0]           pend_nx_s;
   logic [NREQ-1:0]           grant_nx_s;
   logic                      dp_in_nx_s;
   logic [NREQ-1:0]           rsp_nx_s;
   logic                      rsp_data_nx_s;

   // Round-robin search: first eligible requester at or above ptr, with wrap.
   // idx_s carries one extra bit so ptr+offset never overflows before the wrap.
   always_comb begin
      elig_s  = req & ~pend_r & {NREQ{~hold}};
      found_s = 1'b0;
      win_s   = {TAGW{1'b0}};
      idx_s   = {(TAGW+1){1'b0}};
      for (int o = 0; o < NREQ; o++) begin
         idx_s = {1'b0, ptr_r} + (TAGW+1)'(o);
         if (idx_s >= (TAGW+1)'(NREQ)) begin
            idx_s = idx_s - (TAGW+1)'(NREQ);
         end else begin
            idx_s = idx_s;
         end
         if (!found_s && elig_s[idx_s[TAGW-1:0]]) begin
            found_s = 1'b1;
            win_s   = idx_s[TAGW-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

   // Next-state values for pointer, pending set and all registered outputs.
   // A grant and a completion on the same edge always belong to different
   // requesters, because a granted requester must not be pending.
   always_comb begin
      cmp_vld_s = tag_vld_r[LAT];
      cmp_tag_s = tag_r[LAT];
      pend_nx_s = pend_r;
      if (cmp_vld_s) begin
         pend_nx_s = pend_nx_s & ~onehot_f(cmp_tag_s);
      end else begin
         pend_nx_s = pend_nx_s;
      end
      if (found_s) begin
         pend_nx_s  = pend_nx_s | onehot_f(win_s);
         grant_nx_s = onehot_f(win_s);
         dp_in_nx_s = req_data[win_s];
         if (win_s == TAGW'(NREQ - 1)) begin
            ptr_nx_s = {TAGW{1'b0}};
         end else begin
            ptr_nx_s = win_s + TAGW'(1);
         end
      end else begin
         grant_nx_s = {NREQ{1'b0}};
         dp_in_nx_s = 1'b0;
         ptr_nx_s   = ptr_r;
      end
      if (cmp_vld_s) begin
         rsp_nx_s      = onehot_f(cmp_tag_s);
         rsp_data_nx_s = dp_out;
      end else begin
         rsp_nx_s      = {NREQ{1'b0}};
         rsp_data_nx_s = 1'b0;
      end
   end

   // State and output registers; the tag pipe shifts every cycle, matching the datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_r    <= {NREQ{1'b0}};
         ptr_r     <= {TAGW{1'b0}};
         tag_vld_r <= {(LAT+1){1'b0}};
         tag_r     <= {((LAT+1)*TAGW){1'b0}};
         grant     <= {NREQ{1'b0}};
         dp_in     <= 1'b0;
         rsp_valid <= {NREQ{1'b0}};
         rsp_data  <= 1'b0;
         inflight  <= {CNTW{1'b0}};
         drained   <= 1'b1;
      end else begin
         pend_r    <= pend_nx_s;
         ptr_r     <= ptr_nx_s;
         tag_vld_r <= {tag_vld_r[LAT-1:0], found_s};
         tag_r     <= {tag_r[LAT-1:0], win_s};
         grant     <= grant_nx_s;
         dp_in     <= dp_in_nx_s;
         rsp_valid <= rsp_nx_s;
         rsp_data  <= rsp_data_nx_s;
         inflight  <= popcount_f(pend_nx_s);
         drained   <= (popcount_f(pend_nx_s) == {CNTW{1'b0}});
      end
   end

endmodule

// File: tb/tb_dp_issue_sched.sv
// Self-checking bench for dp_issue_sched (NREQ=3, LAT=4). A plain delay line
// stands in for the datapath. Expectations come from a vector table, from
// hand-written sequences and from a queue-based reference model of the
// scheduling rules, which is checked on every cycle.
module tb_dp_issue_sched;
   localparam int NREQ = 3;
   localparam int LAT  = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] req;
   logic [2:0] req_data;
   logic       hold;
   logic [2:0] grant;
   logic       dp_in;
   logic       dp_out;
   logic [2:0] rsp_valid;
   logic       rsp_data;
   logic [1:0] inflight;
   logic       drained;

   int n_chk;
   int n_fail;

   dp_issue_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .hold(hold),
      .grant(grant), .dp_in(dp_in), .dp_out(dp_out), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .inflight(inflight), .drained(drained)
   );

   always #5 clk = ~clk;

   // Datapath stand-in: LAT register stages, no reset, no enable.
   logic [LAT-1:0] dp_pipe = '0;
   always @(posedge clk) dp_pipe <= {dp_pipe[LAT-2:0], dp_in};
   assign dp_out = dp_pipe[LAT-1];

   // ---------------- reference model ----------------
   typedef struct {
      int tag;
      bit data;
      int due;
   } item_t;

   item_t      m_q[$];
   int         m_ptr;
   bit         m_pend[NREQ];
   int         m_edge;
   logic [2:0] e_grant;
   logic [2:0] e_rsp;
   logic       e_dpin;
   logic       e_rdata;
   logic [1:0] e_infl;

   task automatic model_reset();
      m_ptr = 0;
      for (int i = 0; i < NREQ; i++) m_pend[i] = 1'b0;
      m_q.delete();
      m_edge = 0;
   endtask

   task automatic model_edge(input logic [2:0] r, input logic [2:0] d, input logic h);
      int    win;
      int    done_tag;
      int    cnt;
      item_t it;
      e_grant = '0; e_rsp = '0; e_dpin = 1'b0; e_rdata = 1'b0;
      win = -1; done_tag = -1;
      if (m_q.size() > 0 && m_q[0].due == m_edge) begin
         it = m_q.pop_front();
         done_tag = it.tag;
         e_rsp[it.tag] = 1'b1;
         e_rdata = it.data;
      end
      if (!h) begin
         for (int o = 0; o < NREQ; o++) begin
            int i;
            i = (m_ptr + o) % NREQ;
            if (win < 0 && r[i] && !m_pend[i]) win = i;
         end
      end
      if (win >= 0) begin
         e_grant[win] = 1'b1;
         e_dpin = d[win];
         m_ptr = (win + 1) % NREQ;
         it.tag = win; it.data = d[win]; it.due = m_edge + LAT + 1;
         m_q.push_back(it);
      end
      if (done_tag >= 0) m_pend[done_tag] = 1'b0;
      if (win >= 0) m_pend[win] = 1'b1;
      cnt = 0;
      for (int i = 0; i < NREQ; i++) cnt += int'(m_pend[i]);
      e_infl = cnt[1:0];
      m_edge++;
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Called at a falling edge: apply inputs, cross the rising edge, compare with the model.
   task automatic step(input logic [2:0] r, input logic [2:0] d, input logic h);
      req = r; req_data = d; hold = h;
      model_edge(r, d, h);
      @(posedge clk); #1;
      chk("model_grant", 32'(grant), 32'(e_grant));
      chk("model_dp_in", 32'(dp_in), 32'(e_dpin));
      chk("model_rsp_valid", 32'(rsp_valid), 32'(e_rsp));
      chk("model_rsp_data", 32'(rsp_data), 32'(e_rdata));
      chk("model_inflight", 32'(inflight), 32'(e_infl));
      chk("model_drained", 32'(drained), 32'(e_infl == 2'd0));
      @(negedge clk);
   endtask

   typedef struct {
      logic [2:0] r;
      logic [2:0] d;
      logic       h;
      logic [2:0] g;
      logic       di;
      logic [2:0] rv;
      logic       rd;
      logic [1:0] inf;
   } vec_t;

   vec_t tbl[20];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0; n_fail = 0;
      req = '0; req_data = '0; hold = 1'b0; rst_n = 1'b0;
      model_reset();

      // round robin, re-issue after completion, hold, release of hold, drain
      tbl[0]  = '{3'b111, 3'b101, 1'b0, 3'b001, 1'b1, 3'b000, 1'b0, 2'd1};
      tbl[1]  = '{3'b111, 3'b101, 1'b0, 3'b010, 1'b0, 3'b000, 1'b0, 2'd2};
      tbl[2]  = '{3'b111, 3'b101, 1'b0, 3'b100, 1'b1, 3'b000, 1'b0, 2'd3};
      tbl[3]  = '{3'b111, 3'b101, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'd3};
      tbl[4]  = '{3'b111, 3'b101, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'd3};
      tbl[5]  = '{3'b111, 3'b101, 1'b0, 3'b000, 1'b0, 3'b001, 1'b1, 2'd2};
      tbl[6]  = '{3'b111, 3'b110, 1'b0, 3'b001, 1'b0, 3'b010, 1'b0, 2'd2};
      tbl[7]  = '{3'b111, 3'b110, 1'b0, 3'b010, 1'b1, 3'b100, 1'b1, 2'd2};
      tbl[8]  = '{3'b111, 3'b110, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 2'd2};
      tbl[9]  = '{3'b111, 3'b110, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 2'd2};
      tbl[10] = '{3'b111, 3'b110, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 2'd2};
      tbl[11] = '{3'b111, 3'b110, 1'b1, 3'b000, 1'b0, 3'b001, 1'b0, 2'd1};
      tbl[12] = '{3'b111, 3'b110, 1'b1, 3'b000, 1'b0, 3'b010, 1'b1, 2'd0};
      tbl[13] = '{3'b111, 3'b110, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 2'd0};
      tbl[14] = '{3'b111, 3'b110, 1'b0, 3'b100, 1'b1, 3'b000, 1'b0, 2'd1};
      tbl[15] = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'd1};
      tbl[16] = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'd1};
      tbl[17] = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'd1};
      tbl[18] = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'd1};
      tbl[19] = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b100, 1'b1, 2'd0};

      repeat (2) @(negedge clk);
      chk("reset_grant", 32'(grant), 32'd0);
      chk("reset_dp_in", 32'(dp_in), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_data", 32'(rsp_data), 32'd0);
      chk("reset_inflight", 32'(inflight), 32'd0);
      chk("reset_drained", 32'(drained), 32'd1);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         step(tbl[i].r, tbl[i].d, tbl[i].h);
         chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].g));
         chk($sformatf("tbl%0d_dp_in", i), 32'(dp_in), 32'(tbl[i].di));
         chk($sformatf("tbl%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].rv));
         chk($sformatf("tbl%0d_rsp_data", i), 32'(rsp_data), 32'(tbl[i].rd));
         chk($sformatf("tbl%0d_inflight", i), 32'(inflight), 32'(tbl[i].inf));
      end

      // wrap and fairness: pointer moved to 2, then req=101
      step(3'b010, 3'b000, 1'b0);
      chk("wrap_setup_grant", 32'(grant), 32'(3'b010));
      step(3'b101, 3'b101, 1'b0);
      chk("wrap_grant_2", 32'(grant), 32'(3'b100));
      step(3'b101, 3'b101, 1'b0);
      chk("wrap_grant_0", 32'(grant), 32'(3'b001));
      step(3'b101, 3'b101, 1'b0);
      chk("wrap_no_repeat", 32'(grant), 32'(3'b000));
      repeat (8) step(3'b000, 3'b000, 1'b0);
      chk("wrap_drained", 32'(drained), 32'd1);

      // requester 0 completes on the same edge requester 1 is granted
      step(3'b001, 3'b001, 1'b0);
      chk("sim_grant0", 32'(grant), 32'(3'b001));
      repeat (4) step(3'b000, 3'b000, 1'b0);
      chk("sim_inflight_before", 32'(inflight), 32'd1);
      step(3'b010, 3'b000, 1'b0);
      chk("sim_grant1", 32'(grant), 32'(3'b010));
      chk("sim_rsp0", 32'(rsp_valid), 32'(3'b001));
      chk("sim_rsp_data", 32'(rsp_data), 32'd1);
      chk("sim_inflight_after", 32'(inflight), 32'd1);
      repeat (6) step(3'b000, 3'b000, 1'b0);

      // reset mid-cycle with two items in flight
      step(3'b111, 3'b111, 1'b0);
      step(3'b111, 3'b111, 1'b0);
      chk("prerst_inflight", 32'(inflight), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_grant", 32'(grant), 32'd0);
      chk("midrst_dp_in", 32'(dp_in), 32'd0);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_inflight", 32'(inflight), 32'd0);
      chk("midrst_drained", 32'(drained), 32'd1);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(3'b000, 3'b000, 1'b0);
         chk($sformatf("postrst%0d_rsp_valid", i), 32'(rsp_valid), 32'd0);
         chk($sformatf("postrst%0d_drained", i), 32'(drained), 32'd1);
      end

      // randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         logic [2:0] r;
         logic [2:0] d;
         logic       h;
         r = 3'($urandom | $urandom);
         d = 3'($urandom);
         h = ($urandom_range(0, 7) == 0);
         step(r, d, h);
      end
      repeat (8) step(3'b000, 3'b000, 1'b0);
      chk("final_drained", 32'(drained), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
